clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- CH-channel programmable clock/tick generator; successor to the fixed single-channel divider.
- Each channel has a runtime-loadable W-bit divide value, an enable, a near-50% registered clk_o and a one-cycle tick at each period start.
- A divide-value change never glitches the output: it is shadowed and takes effect on the next period boundary.
- Sits beside the system clock and feeds slow strobes (display scan, debounce, UART baud) to peripheral blocks.

Parameters:
- CH, 4, number of independent channels.
- W, 32, width of divide value and per-channel counter.
- DEF_DIV, 50000000, divide value loaded into every channel at reset; must be < 2^W.

Ports:
- clk  in  1  system clock (50 MHz); all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  CH  per-channel enable, level-sensitive.
- div_load  in  CH  per-channel one-cycle strobe to load the new divide value.
- div_in  in  CH*W  packed divide values; channel i uses bits [i*W +: W].
- clk_o  out  CH  divided clock per channel, registered.
- tick  out  CH  one-cycle pulse at the first cycle of each period, registered.
- pend  out  CH  high while a loaded divide value waits for the period boundary.

Behaviour:
- Per-channel state: cnt[W], div_act[W], div_pend[W], pend, armed, clk_o, tick. Channels are fully independent.
- Reset (rst=0, async): cnt=0, div_act=DEF_DIV, div_pend=0, pend=0, armed=1, clk_o=0, tick=0.
- Disabled (en[i]=0):
  - cnt<=0, armed<=1, clk_o<=0, tick<=0.
  - div_load applies immediately (div_act<=div_in) and clears pend.
- Wrap condition, evaluated when enabled: armed=1, OR cnt >= div_act-1, OR div_act<2.
- Enabled, wrap:
  - cnt<=0, armed<=0, tick<=(div_act_next != 0).
  - div_act_next = div_in if div_load is high this cycle; else div_pend if pend; else div_act.
  - div_act<=div_act_next; pend<=0.
- Enabled, no wrap:
  - cnt<=cnt+1, tick<=0.
  - If div_load: div_pend<=div_in, pend<=1. The last load before a boundary wins.
- clk_o (registered): clk_o <= en && (div_act_next>=2) && (cnt_next < (div_act_next+1)>>1).
  - Duty: high for ceil(D/2) cycles, low for floor(D/2) cycles; period exactly D cycles.
- Special divide values:
  - D=0: channel halted; clk_o=0, tick=0, cnt stays 0. A later load still takes effect, because D<2 forces a wrap every cycle.
  - D=1: tick high every enabled cycle, clk_o=0.
- Latency:
  - First enabled edge after en rises: tick=1 and clk_o=1 (for D>=2) both visible after that edge.
  - en falling: clk_o and tick are 0 after the next edge. No partial-period completion.
- Comparisons are unsigned W-bit. cnt never exceeds div_act-1, so it never wraps at 2^W.
- The cnt >= div_act-1 guard makes the channel recover within one cycle even if div_act shrinks below cnt.
- Reset mid-period: everything returns to reset values asynchronously. The first period after reset release starts on the first enabled edge.

Test Plan:
- Reset with DEF_DIV=4, hold en=1 after release -> tick on edges 1,5,9…; clk_o pattern 1,1,0,0 repeating; pend=0.
- Channel 0 D=3 loaded while disabled, then enable -> clk_o 1,1,0 repeating, tick every 3rd cycle; other channels unaffected.
- Channel running D=8, load D=2 at cnt=3 -> pend=1 for 4 cycles; clk_o finishes the 8-cycle period (4 high/4 low), then toggles every cycle; pend falls at the wrap.
- Load D=6 on the exact wrap cycle of D=4 -> the next period is 6 cycles, pend never asserts.
- D=1 -> tick constant 1, clk_o 0. D=0 -> tick 0, clk_o 0. Then load D=2 -> a tick appears on the next edge and clk_o toggles.
- Drop en mid-high phase, and separately assert rst mid-period -> clk_o=0 after the next edge (en) or immediately (rst); re-enable restarts with tick=1 and clk_o=1.

Source files
------------

// File: rtl/clock_divider_multi_if.sv
// Control/status bundle of the multi-channel clock divider.
// The master side drives enables and divide loads; the slave side is the divider itself.
interface clock_divider_multi_if #(
  parameter int CH = 4,
  parameter int W  = 32
);
  logic [CH-1:0]   en;
  logic [CH-1:0]   div_load;
  logic [CH*W-1:0] div_in;
  logic [CH-1:0]   clk_o;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pend;

  modport master (
    output en,
    output div_load,
    output div_in,
    input  clk_o,
    input  tick,
    input  pend
  );

  modport slave (
    input  en,
    input  div_load,
    input  div_in,
    output clk_o,
    output tick,
    output pend
  );
endinterface

// File: rtl/clock_divider_multi.sv
// CH independent programmable dividers, each with a registered near-50% clock,
// a period-start tick and a shadowed divide value that switches only at period boundaries.
module clock_divider_multi #(
  parameter int          CH      = 4,
  parameter int          W       = 32,
  parameter logic [63:0] DEF_DIV = 64'd50000000
) (
  input logic                  clk,
  input logic                  rst,
  clock_divider_multi_if.slave bus
);

  localparam logic [W-1:0] DEF_DIV_W = DEF_DIV[W-1:0];
  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] TWO       = W'(2);

  logic [CH-1:0] clk_o_vec;
  logic [CH-1:0] tick_vec;
  logic [CH-1:0] pend_vec;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] cnt_reg;
      logic [W-1:0] cnt_next;
      logic [W-1:0] div_act_reg;
      logic [W-1:0] div_act_next;
      logic [W-1:0] div_pend_reg;
      logic [W-1:0] div_pend_next;
      logic         pend_reg;
      logic         pend_next;
      logic         armed_reg;
      logic         armed_next;
      logic         clk_o_reg;
      logic         clk_o_next;
      logic         tick_reg;
      logic         tick_next;

      logic         ch_en;
      logic         ch_load;
      logic [W-1:0] ch_din;
      logic         wrap;
      logic [W:0]   high_len;

      assign ch_en   = bus.en[gi];
      assign ch_load = bus.div_load[gi];
      assign ch_din  = bus.div_in[gi*W +: W];

      // div_act < 2 is tested first so the div_act-1 underflow at 0 is harmless;
      // the >= form recovers within a cycle if div_act ever drops below cnt.
      assign wrap = armed_reg
                 || (div_act_reg < TWO)
                 || (cnt_reg >= (div_act_reg - ONE));

      // Per-channel state update
      always_comb begin
        cnt_next      = cnt_reg;
        div_act_next  = div_act_reg;
        div_pend_next = div_pend_reg;
        pend_next     = pend_reg;
        armed_next    = armed_reg;
        tick_next     = 1'b0;

        if (!ch_en) begin
          cnt_next   = '0;
          armed_next = 1'b1;
          if (ch_load) begin
            div_act_next = ch_din;
            pend_next    = 1'b0;
          end
        end else if (wrap) begin
          cnt_next   = '0;
          armed_next = 1'b0;
          pend_next  = 1'b0;
          if (ch_load) begin
            div_act_next = ch_din;
          end else if (pend_reg) begin
            div_act_next = div_pend_reg;
          end
          tick_next = (div_act_next != '0);
        end else begin
          cnt_next = cnt_reg + ONE;
          if (ch_load) begin
            div_pend_next = ch_din;
            pend_next     = 1'b1;
          end
        end
      end

      // One extra bit keeps ceil(D/2) exact for D = 2^W-1.
      assign high_len = ({1'b0, div_act_next} + {{W{1'b0}}, 1'b1}) >> 1;

      always_comb begin
        clk_o_next = ch_en
                  && (div_act_next >= TWO)
                  && ({1'b0, cnt_next} < high_len);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg      <= '0;
          div_act_reg  <= DEF_DIV_W;
          div_pend_reg <= '0;
          pend_reg     <= 1'b0;
          armed_reg    <= 1'b1;
          clk_o_reg    <= 1'b0;
          tick_reg     <= 1'b0;
        end else begin
          cnt_reg      <= cnt_next;
          div_act_reg  <= div_act_next;
          div_pend_reg <= div_pend_next;
          pend_reg     <= pend_next;
          armed_reg    <= armed_next;
          clk_o_reg    <= clk_o_next;
          tick_reg     <= tick_next;
        end
      end

      assign clk_o_vec[gi] = clk_o_reg;
      assign tick_vec[gi]  = tick_reg;
      assign pend_vec[gi]  = pend_reg;
    end
  endgenerate

  assign bus.clk_o = clk_o_vec;
  assign bus.tick  = tick_vec;
  assign bus.pend  = pend_vec;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios followed by random enables/loads/resets,
// every cycle compared against a period-position model of each channel.
module tb_clock_divider_multi;

  localparam int CH = 4;
  localparam int W  = 32;
  localparam int DEF = 4;

  logic clk;
  logic rst;

  clock_divider_multi_if #(.CH(CH), .W(W)) bus ();

  clock_divider_multi #(.CH(CH), .W(W), .DEF_DIV(64'(DEF))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: current period length, position inside the period, queued length.
  longint unsigned m_d   [CH];
  longint unsigned m_pd  [CH];
  longint unsigned m_pos [CH];
  bit              m_run [CH];
  bit              m_pend[CH];
  bit              m_tick[CH];
  bit              m_clk [CH];

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_d[i] = DEF; m_pd[i] = 0; m_pos[i] = 0;
      m_run[i] = 0; m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
    end
  endfunction

  function automatic void model_update(logic [CH-1:0] e, logic [CH-1:0] l, logic [CH*W-1:0] din);
    for (int i = 0; i < CH; i++) begin
      longint unsigned v;
      v = longint'(din[i*W +: W]);
      if (!e[i]) begin
        m_run[i] = 0; m_pos[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        if (l[i]) begin m_d[i] = v; m_pend[i] = 0; end
      end else begin
        if (!m_run[i] || m_d[i] < 2 || m_pos[i] == m_d[i] - 1) begin
          if (l[i]) m_d[i] = v;
          else if (m_pend[i]) m_d[i] = m_pd[i];
          m_pend[i] = 0; m_run[i] = 1; m_pos[i] = 0;
          m_tick[i] = (m_d[i] != 0);
        end else begin
          m_pos[i] = m_pos[i] + 1;
          m_tick[i] = 0;
          if (l[i]) begin m_pd[i] = v; m_pend[i] = 1; end
        end
        m_clk[i] = (m_d[i] >= 2) && (m_pos[i] < (m_d[i] + 1) / 2);
      end
    end
  endfunction

  task automatic chk(string tag, logic [CH-1:0] obs, logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(string tag);
    logic [CH-1:0] ec, et, ep;
    for (int i = 0; i < CH; i++) begin
      ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
    end
    chk({tag, ".clk_o"}, bus.clk_o, ec);
    chk({tag, ".tick"},  bus.tick,  et);
    chk({tag, ".pend"},  bus.pend,  ep);
  endtask

  // One clock: capture inputs, edge, advance model, compare, drop load strobes.
  task automatic step(string tag);
    logic [CH-1:0]   e;
    logic [CH-1:0]   l;
    logic [CH*W-1:0] d;
    e = bus.en; l = bus.div_load; d = bus.div_in;
    if (l != '0) $display("load en=%b mask=%b div_in=%h (%s)", e, l, d, tag);
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(e, l, d);
    #1;
    compare_all(tag);
    bus.div_load = '0;
  endtask

  task automatic load(int ch, int unsigned val);
    bus.div_in[ch*W +: W] = W'(val);
    bus.div_load[ch] = 1'b1;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bus.en = '0;
    bus.div_load = '0;
    bus.div_in = '0;
    model_reset();

    // Reset state and default-divide run
    #12;
    compare_all("reset");
    bus.en = '1;
    @(negedge clk);
    rst = 1'b1;
    $display("phase: default divide");
    step("def_first");
    chk("def_first_tick", bus.tick, 4'b1111);
    chk("def_first_clk", bus.clk_o, 4'b1111);
    for (int k = 0; k < 11; k++) step("def");

    // Channel 0: D=3 loaded while disabled
    $display("phase: ch0 D=3");
    bus.en[0] = 1'b0; load(0, 3); step("ch0_dis");
    bus.en[0] = 1'b1;
    for (int k = 0; k < 9; k++) step("ch0_d3");

    // Channel 1: D=8 then D=2 loaded at cnt=3
    $display("phase: ch1 8->2");
    bus.en[1] = 1'b0; load(1, 8); step("ch1_dis");
    bus.en[1] = 1'b1;
    for (int k = 0; k < 4; k++) step("ch1_d8");
    load(1, 2); step("ch1_ld2");
    chk("ch1_pend_set", bus.pend & 4'b0010, 4'b0010);
    for (int k = 0; k < 10; k++) step("ch1_run");

    // Channel 2: load D=6 exactly on a D=4 wrap cycle
    $display("phase: ch2 wrap load");
    guard = 0;
    while (!(m_run[2] && m_pos[2] == m_d[2] - 1) && guard < 20) begin
      step("ch2_wait"); guard++;
    end
    chk("ch2_wait_bound", (guard < 20) ? 4'b0000 : 4'b0100, 4'b0000);
    load(2, 6); step("ch2_ld6");
    chk("ch2_no_pend", bus.pend & 4'b0100, 4'b0000);
    for (int k = 0; k < 13; k++) step("ch2_d6");

    // Channel 3: D=1, D=0, then D=2
    $display("phase: ch3 special values");
    load(3, 1); for (int k = 0; k < 6; k++) step("ch3_d1");
    chk("ch3_d1_tick", bus.tick & 4'b1000, 4'b1000);
    load(3, 0); for (int k = 0; k < 4; k++) step("ch3_d0");
    chk("ch3_d0_tick", bus.tick & 4'b1000, 4'b0000);
    load(3, 2); step("ch3_ld2");
    chk("ch3_d2_tick", bus.tick & 4'b1000, 4'b1000);
    for (int k = 0; k < 5; k++) step("ch3_d2");

    // Drop en mid-high phase on channel 0
    $display("phase: en drop / async reset");
    guard = 0;
    while (!(m_clk[0] && m_pos[0] == 0) && guard < 10) begin
      step("ch0_wait"); guard++;
    end
    bus.en[0] = 1'b0; step("ch0_off");
    chk("ch0_off_clk", bus.clk_o & 4'b0001, 4'b0000);
    bus.en[0] = 1'b1; step("ch0_on");
    chk("ch0_on_tick", bus.tick & 4'b0001, 4'b0001);
    chk("ch0_on_clk", bus.clk_o & 4'b0001, 4'b0001);
    step("ch0_run"); step("ch0_run");

    // Asynchronous reset mid-period
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    chk("async_rst_clk", bus.clk_o, 4'b0000);
    step("in_rst");
    @(negedge clk);
    rst = 1'b1;
    step("rst_rel");
    chk("rst_rel_tick", bus.tick, 4'b1111);
    for (int k = 0; k < 6; k++) step("post_rst");

    // Random traffic
    $display("phase: random");
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(99) < 4) bus.en[i] = ~bus.en[i];
        if ($urandom_range(99) < 10) load(i, $urandom_range(10));
      end
      if ($urandom_range(999) < 3) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst");
        @(negedge clk);
        rst = 1'b1;
      end
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
